// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter shared definitions: FSM state encoding and clog2 helper.
// Optional start-of-frame watchdog is enabled with UART_TX_ARB_WATCHDOG_EN.
package uart_tx_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE       = 2'd0;
  localparam arb_state_t ST_LAUNCH     = 2'd1;
  localparam arb_state_t ST_WAIT_START = 2'd2;
  localparam arb_state_t ST_WAIT_DONE  = 2'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester bus + UART transmit pins shared by the arbiter and its environment.
// wdog_err is present only when UART_TX_ARB_WATCHDOG_EN is defined.
interface uart_tx_arbiter_if
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int IDX_W = clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      uart_transmit;
  logic [DATA_W-1:0]         uart_tx_byte;
  logic                      uart_is_transmitting;
  logic [IDX_W-1:0]          grant_id;
  logic                      busy;
`ifdef UART_TX_ARB_WATCHDOG_EN
  logic                      wdog_err;
`endif

  modport slave (
    input  req_valid,
    input  req_data,
    input  uart_is_transmitting,
    output req_ready,
    output uart_transmit,
    output uart_tx_byte,
    output grant_id,
`ifdef UART_TX_ARB_WATCHDOG_EN
    output wdog_err,
`endif
    output busy
  );

  modport master (
    output req_valid,
    output req_data,
    output uart_is_transmitting,
    input  req_ready,
    input  uart_transmit,
    input  uart_tx_byte,
    input  grant_id,
`ifdef UART_TX_ARB_WATCHDOG_EN
    input  wdog_err,
`endif
    input  busy
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first valid index after ptr, wrapping.
// Used by uart_tx_arbiter (UART_TX_ARB_WATCHDOG_EN does not affect it).
module rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any_req
);

  // w_cand[k] is the k-th index searched: ptr+1, ptr+2, ... mod NUM_REQ
  logic [IDX_W-1:0] w_cand [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
    assign w_cand[k] = IDX_W'((int'(ptr) + k + 1) % NUM_REQ);
  end

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any_req    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_req && req[w_cand[k]]) begin
        any_req             = 1'b1;
        gnt_idx             = w_cand[k];
        gnt_onehot[w_cand[k]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between NUM_REQ byte producers.
// Define UART_TX_ARB_WATCHDOG_EN to add the start-of-frame watchdog (wdog_err).
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int WDOG_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDX_W = clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 2) begin : g_bad_cfg
    $error("uart_tx_arbiter: parameter out of range");
  end

  arb_state_t        r_state;
  logic              r_tx;
  logic [DATA_W-1:0] r_byte;
  logic [IDX_W-1:0]  r_ptr;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic               w_free;
  logic [DATA_W-1:0]  w_byte;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (bus.req_valid),
    .ptr        (r_ptr),
    .gnt_onehot (w_gnt),
    .gnt_idx    (w_idx),
    .any_req    (w_any)
  );

  // a frame left in flight by a reset still blocks arbitration
  assign w_free = (r_state == ST_IDLE) && !bus.uart_is_transmitting;
  assign w_byte = bus.req_data[int'(w_idx)*DATA_W +: DATA_W];

  assign bus.req_ready     = w_free ? w_gnt : '0;
  assign bus.uart_transmit = r_tx;
  assign bus.uart_tx_byte  = r_byte;
  assign bus.grant_id      = r_ptr;
  assign bus.busy          = (r_state != ST_IDLE);

`ifdef UART_TX_ARB_WATCHDOG_EN
  localparam int CW = clog2(WDOG_CYCLES) + 1;

  logic [CW-1:0] r_wcnt;
  logic          r_wdog_err;

  assign bus.wdog_err = r_wdog_err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_tx    <= 1'b0;
      r_byte  <= '0;
      r_ptr   <= IDX_W'(NUM_REQ - 1);
`ifdef UART_TX_ARB_WATCHDOG_EN
      r_wcnt     <= '0;
      r_wdog_err <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_free && w_any) begin
            r_byte  <= w_byte;
            r_ptr   <= w_idx;
            r_tx    <= 1'b1;
            r_state <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          r_tx    <= 1'b0;
          r_state <= ST_WAIT_START;
`ifdef UART_TX_ARB_WATCHDOG_EN
          // the launch cycle counts toward the limit
          r_wcnt  <= CW'(1);
`endif
        end
        ST_WAIT_START: begin
          if (bus.uart_is_transmitting) begin
            r_state <= ST_WAIT_DONE;
`ifdef UART_TX_ARB_WATCHDOG_EN
          end else if (r_wcnt == CW'(WDOG_CYCLES - 1)) begin
            r_state    <= ST_IDLE;
            r_wdog_err <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt + CW'(1);
`endif
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.uart_is_transmitting) r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter (9600 baud, 12 MHz system clock) between NUM_REQ byte producers.
- Arbitration is round-robin.
- Each producer presents a byte with a valid/ready handshake.
- The arbiter sequences the transmitter: it pulses transmit, waits for the frame to start, then waits for it to finish.
- It sits between application logic (echo path, status reporters) and the UART instance's transmit, tx_byte and is_transmitting pins.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; must match the UART tx_byte width.
- WDOG_CYCLES, 16, start-of-frame watchdog limit in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*DATA_W  packed bytes; requester i owns bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot acceptance strobe.
- uart_transmit  out  1  one-cycle start pulse to the UART.
- uart_tx_byte  out  DATA_W  byte to the UART.
- uart_is_transmitting  in  1  UART busy flag.
- grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester.
- busy  out  1  high whenever the state is not IDLE.
- wdog_err  out  1  sticky watchdog flag; exists only with the optional feature.

Behaviour:
- Reset values (rst_n low, asynchronous): state=IDLE, uart_transmit=0, uart_tx_byte=0, grant_id=NUM_REQ-1, rr pointer=NUM_REQ-1, busy=0, wdog_err=0.
- Requester 0 therefore wins the first arbitration.
- States: IDLE, LAUNCH, WAIT_START, WAIT_DONE.
- IDLE:
  - Arbitration happens only when uart_is_transmitting==0. This covers a frame still in flight after a mid-frame reset.
  - Search order: pointer+1, pointer+2, ... wrapping modulo NUM_REQ; the first index with req_valid set wins.
  - req_ready[w] is combinational and high in this cycle only. The transfer occurs on the same edge.
  - On that edge: latch req_data[w] into uart_tx_byte, set grant_id=w and pointer=w, go to LAUNCH.
  - With no valid request, or the UART busy: stay in IDLE, req_ready=0.
- LAUNCH: uart_transmit=1 for exactly this one cycle. Next state is WAIT_START.
- WAIT_START: uart_transmit=0. Go to WAIT_DONE when uart_is_transmitting==1.
- WAIT_DONE: go to IDLE when uart_is_transmitting==0.
- uart_tx_byte is held stable from LAUNCH until the next grant.
- Latency: req_valid seen in IDLE at cycle 0 gives req_ready at cycle 0 and uart_transmit at cycle 1. Earliest next grant is the cycle after is_transmitting falls.
- Handshake: a requester holds valid and data stable until it sees ready. Dropping valid before ready is legal and simply withdraws the request; no byte is lost or duplicated.
- Simultaneous requests: only one ready per cycle. A requester that is continuously valid waits at most NUM_REQ-1 grants (fairness).
- A single requester that stays valid is granted back-to-back frames.
- Reset asserted in any state forces IDLE immediately. A partially sent byte is abandoned and the request is not re-issued.

Optional Feature:
- Macro: UART_TX_ARB_WATCHDOG_EN.
- Defined:
  - WAIT_START counts cycles.
  - If uart_is_transmitting has not risen after WDOG_CYCLES cycles, return to IDLE and set wdog_err (sticky until reset).
  - The byte is dropped and the pointer still advances.
- Undefined: WAIT_START waits indefinitely. There is no wdog_err port and no counter logic.

Decomposition:
- Package uart_tx_arb_pkg: the state encoding (2-bit localparams ST_IDLE=0, ST_LAUNCH=1, ST_WAIT_START=2, ST_WAIT_DONE=3) and the clog2 helper function.
- One sub-module, rr_pick. It is combinational round-robin selection with inputs req[NUM_REQ] and ptr, and outputs gnt_onehot, gnt_idx and any_req.
- The FSM and datapath stay in uart_tx_arbiter.

Test Plan:
- Single request: req_valid=4'b0001, data 0x41, UART model asserts busy 1 cycle after transmit for 10 cycles. Expect req_ready[0] one cycle, uart_transmit at the next cycle, uart_tx_byte=0x41, return to IDLE when busy drops.
- All four valid, data 0x10/0x20/0x30/0x40 held. Expect grant order 0,1,2,3,0 and bytes 0x10,0x20,0x30,0x40,0x10 on successive uart_transmit pulses.
- Requester 2 continuously valid, requester 1 asserts mid-frame. Expect the next grant to go to requester 3 only if it is valid, otherwise wrap to 1; requester 1 is served within 3 grants.
- uart_is_transmitting held high at reset release with req_valid=4'b1000. Expect no req_ready until busy falls, then a grant to requester 3.
- rst_n pulsed low during WAIT_DONE. Expect immediate IDLE, uart_transmit=0, pointer=3, busy=0. After release, the first grant goes to requester 0.
- With UART_TX_ARB_WATCHDOG_EN and the UART model never asserting busy: wdog_err rises 16 cycles after the transmit pulse, and the FSM returns to IDLE and serves the next requester.
